// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / monitor) arbiter for a shared 8-bit memory bus.
// One transaction at a time: IDLE -> ACCESS -> WAIT -> DONE, with round-robin on ties.
module mem_bus_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       mon_req,
    input  logic       mon_we,
    input  logic [7:0] mon_addr,
    input  logic [7:0] mon_wdata,
    output logic       mon_ack,
    output logic [7:0] mon_rdata,
    input  logic       halt_req,
    output logic       halted,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } state_e;

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnMon = 1'b1
    } owner_e;

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    owner_e     last_grant_q, last_grant_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] mon_rdata_q, mon_rdata_d;
    logic       halted_q, halted_d;

    logic   cpu_eligible;
    logic   grant_valid;
    owner_e grant_owner;
    logic   cpu_txn;

    // Arbitration: the CPU is locked out while halt_req is high.
    always_comb begin
        cpu_eligible = cpu_req & ~halt_req;
        grant_valid  = cpu_eligible | mon_req;
        grant_owner  = OwnCpu;
        if (cpu_eligible && mon_req) begin
            grant_owner = (last_grant_q == OwnMon) ? OwnCpu : OwnMon;
        end else if (mon_req) begin
            grant_owner = OwnMon;
        end
    end

    // A CPU transaction still using the bus defers entry into the halted state.
    assign cpu_txn = ((state_q == StAccess) || (state_q == StWait)) && (owner_q == OwnCpu);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        mon_rdata_d  = mon_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d      = StAccess;
                    owner_d      = grant_owner;
                    last_grant_d = grant_owner;
                    if (grant_owner == OwnMon) begin
                        we_d    = mon_we;
                        addr_d  = mon_addr;
                        wdata_d = mon_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            StAccess: begin
                state_d = StWait;
            end
            StWait: begin
                state_d = StDone;
                if (!we_q) begin
                    if (owner_q == OwnMon) begin
                        mon_rdata_d = bus_rdata;
                    end else begin
                        cpu_rdata_d = bus_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!halt_req) begin
            halted_d = 1'b0;
        end else if (!cpu_txn) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnCpu;
            last_grant_q <= OwnMon;
            we_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            cpu_rdata_q  <= 8'h00;
            mon_rdata_q  <= 8'h00;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mon_rdata_q  <= mon_rdata_d;
            halted_q     <= halted_d;
        end
    end

    // Bus outputs decode from registered state only, so they are quiet outside ACCESS/WAIT.
    always_comb begin
        bus_we    = 1'b0;
        bus_addr  = 8'h00;
        bus_wdata = 8'h00;
        unique case (state_q)
            StAccess: begin
                bus_we    = we_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
            end
            StWait: begin
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
            end
            default: begin
                bus_we    = 1'b0;
                bus_addr  = 8'h00;
                bus_wdata = 8'h00;
            end
        endcase
    end

    assign cpu_ack   = (state_q == StDone) && (owner_q == OwnCpu);
    assign mon_ack   = (state_q == StDone) && (owner_q == OwnMon);
    assign cpu_rdata = cpu_rdata_q;
    assign mon_rdata = mon_rdata_q;
    assign halted    = halted_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b1;
    logic       cpu_req   = 1'b0;
    logic       cpu_we    = 1'b0;
    logic [7:0] cpu_addr  = 8'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic       mon_req   = 1'b0;
    logic       mon_we    = 1'b0;
    logic [7:0] mon_addr  = 8'h00;
    logic [7:0] mon_wdata = 8'h00;
    logic       halt_req  = 1'b0;
    logic [7:0] bus_rdata = 8'h00;

    logic       cpu_ack, mon_ack, halted, bus_we, busy;
    logic [7:0] cpu_rdata, mon_rdata, bus_addr, bus_wdata;

    mem_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mon_req   (mon_req),
        .mon_we    (mon_we),
        .mon_addr  (mon_addr),
        .mon_wdata (mon_wdata),
        .mon_ack   (mon_ack),
        .mon_rdata (mon_rdata),
        .halt_req  (halt_req),
        .halted    (halted),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a transaction granted in cycle g occupies cycles g+1 (bus access),
    // g+2 (read data returns) and g+3 (acknowledge).
    int         cyc       = 0;
    int         grant_cyc = 0;
    bit         txn_valid = 1'b0;
    bit         m_own_mon = 1'b0;
    bit         m_we      = 1'b0;
    bit         m_last_mon = 1'b1;
    bit         m_halted  = 1'b0;
    logic [7:0] m_addr    = 8'h00;
    logic [7:0] m_wdata   = 8'h00;
    logic [7:0] m_rd_cpu  = 8'h00;
    logic [7:0] m_rd_mon  = 8'h00;

    bit cpu_pend = 1'b0;
    bit mon_pend = 1'b0;
    int ack_who[$];
    int ack_when[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic int txn_age();
        return txn_valid ? (cyc - grant_cyc) : 0;
    endfunction

    // Apply the rules to the inputs present just before the clock edge.
    task automatic model_edge();
        int a;
        bit act, cpu_ok, pick_mon;
        a   = txn_age();
        act = (a >= 1) && (a <= 3);
        if (reset) begin
            txn_valid  = 1'b0;
            m_last_mon = 1'b1;
            m_halted   = 1'b0;
            m_rd_cpu   = 8'h00;
            m_rd_mon   = 8'h00;
        end else begin
            if (!halt_req) m_halted = 1'b0;
            else if (!(act && (a <= 2) && !m_own_mon)) m_halted = 1'b1;
            if (act && (a == 2) && !m_we) begin
                if (m_own_mon) m_rd_mon = bus_rdata;
                else m_rd_cpu = bus_rdata;
            end
            if (!act) begin
                cpu_ok = cpu_req && !halt_req;
                if (mon_req || cpu_ok) begin
                    pick_mon   = mon_req && (!cpu_ok || !m_last_mon);
                    m_own_mon  = pick_mon;
                    m_last_mon = pick_mon;
                    m_we       = pick_mon ? mon_we : cpu_we;
                    m_addr     = pick_mon ? mon_addr : cpu_addr;
                    m_wdata    = pick_mon ? mon_wdata : cpu_wdata;
                    txn_valid  = 1'b1;
                    grant_cyc  = cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_model();
        int a;
        bit act;
        a   = txn_age();
        act = (a >= 1) && (a <= 3);
        chk("busy", 8'(busy), 8'(act));
        chk("bus_we", 8'(bus_we), 8'(act && (a == 1) && m_we));
        chk("bus_addr", bus_addr, (act && (a <= 2)) ? m_addr : 8'h00);
        if (!(act && (a == 2)))
            chk("bus_wdata", bus_wdata, (act && (a == 1)) ? m_wdata : 8'h00);
        chk("cpu_ack", 8'(cpu_ack), 8'(act && (a == 3) && !m_own_mon));
        chk("mon_ack", 8'(mon_ack), 8'(act && (a == 3) && m_own_mon));
        chk("halted", 8'(halted), 8'(m_halted));
        chk("cpu_rdata", cpu_rdata, m_rd_cpu);
        chk("mon_rdata", mon_rdata, m_rd_mon);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_halted", 8'(halted), 8'h00);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        reset = 1'b0;
        step();

        // CPU read of 0x10 returning 0x5A; address changed after grant must not matter
        bus_rdata = 8'h5A;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        step();
        chk("r30_acc_addr", bus_addr, 8'h10);
        chk("r30_acc_we", 8'(bus_we), 8'h00);
        cpu_addr = 8'h77;
        step();
        chk("r30_wait_addr", bus_addr, 8'h10);
        step();
        chk("r30_ack", 8'(cpu_ack), 8'h01);
        chk("r30_rdata", cpu_rdata, 8'h5A);
        cpu_req = 1'b0;
        step();
        chk("r30_idle_busy", 8'(busy), 8'h00);

        // Monitor write 0xC3 to 0xFF
        mon_req = 1'b1; mon_we = 1'b1; mon_addr = 8'hFF; mon_wdata = 8'hC3;
        step();
        chk("r31_we", 8'(bus_we), 8'h01);
        chk("r31_addr", bus_addr, 8'hFF);
        chk("r31_wdata", bus_wdata, 8'hC3);
        mon_wdata = 8'h00;
        step();
        chk("r31_wait_we", 8'(bus_we), 8'h00);
        step();
        chk("r31_mon_ack", 8'(mon_ack), 8'h01);
        chk("r31_cpu_ack", 8'(cpu_ack), 8'h00);
        mon_req = 1'b0;
        step();

        // Both requesting continuously from reset: CPU, MON, CPU, MON
        reset = 1'b1;
        step();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
        mon_req = 1'b1; mon_we = 1'b0; mon_addr = 8'h42;
        for (int i = 0; i < 17; i++) begin
            bus_rdata = 8'(i * 7 + 3);
            step();
            if (cpu_ack) begin ack_who.push_back(0); ack_when.push_back(cyc); end
            if (mon_ack) begin ack_who.push_back(1); ack_when.push_back(cyc); end
        end
        chk("r32_ack_count", 8'(ack_who.size()), 8'd4);
        for (int i = 0; i < 4 && i < ack_who.size(); i++) begin
            chk("r32_ack_owner", 8'(ack_who[i]), 8'(i % 2));
            if (i > 0) chk("r32_ack_gap", 8'(ack_when[i] - ack_when[i-1]), 8'd4);
        end
        cpu_req = 1'b0; mon_req = 1'b0;
        for (int k = 0; k < 6 && busy; k++) step();
        chk("r32_drained", 8'(busy), 8'h00);

        // Halt raised during a CPU access
        bus_rdata = 8'h3C;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h55;
        step();
        halt_req = 1'b1;
        step();
        chk("r33_not_yet_halted", 8'(halted), 8'h00);
        step();
        chk("r33_cpu_ack", 8'(cpu_ack), 8'h01);
        step();
        chk("r33_halted", 8'(halted), 8'h01);
        step();
        chk("r33_cpu_ignored", 8'(busy), 8'h00);
        mon_req = 1'b1; mon_we = 1'b1; mon_addr = 8'h33; mon_wdata = 8'h44;
        step();
        chk("r33_mon_we", 8'(bus_we), 8'h01);
        step();
        step();
        chk("r33_mon_ack", 8'(mon_ack), 8'h01);
        mon_req = 1'b0; halt_req = 1'b0;
        step();
        chk("r33_unhalted", 8'(halted), 8'h00);
        step();
        chk("r33_cpu_addr", bus_addr, 8'h55);
        step();
        step();
        chk("r33_cpu_ack2", 8'(cpu_ack), 8'h01);
        cpu_req = 1'b0;
        step();

        // Reset during WAIT of a CPU read
        bus_rdata = 8'hA5;
        cpu_req = 1'b1; cpu_addr = 8'h20;
        step();
        step();
        reset = 1'b1; cpu_req = 1'b0;
        step();
        chk("r34_busy", 8'(busy), 8'h00);
        chk("r34_ack", 8'(cpu_ack), 8'h00);
        chk("r34_rdata", cpu_rdata, 8'h00);
        reset = 1'b0;
        step();

        // Random traffic with halts and occasional resets
        for (int i = 0; i < 600; i++) begin
            int a;
            bit ack_c, ack_m;
            step();
            a     = txn_age();
            ack_c = txn_valid && (a == 3) && !m_own_mon;
            ack_m = txn_valid && (a == 3) && m_own_mon;
            if (ack_c || (!cpu_pend && $urandom_range(0, 2) == 0) ||
                (txn_valid && (a >= 1) && (a <= 2) && !m_own_mon && $urandom_range(0, 1) == 1)) begin
                if (ack_c) cpu_pend = ($urandom_range(0, 1) == 1);
                else cpu_pend = 1'b1;
                cpu_we    = ($urandom_range(0, 1) == 1);
                cpu_addr  = 8'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (ack_m || (!mon_pend && $urandom_range(0, 2) == 0) ||
                (txn_valid && (a >= 1) && (a <= 2) && m_own_mon && $urandom_range(0, 1) == 1)) begin
                if (ack_m) mon_pend = ($urandom_range(0, 1) == 1);
                else mon_pend = 1'b1;
                mon_we    = ($urandom_range(0, 1) == 1);
                mon_addr  = 8'($urandom);
                mon_wdata = 8'($urandom);
            end
            cpu_req   = cpu_pend;
            mon_req   = mon_pend;
            if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
            reset     = ($urandom_range(0, 79) == 0);
            bus_rdata = 8'($urandom);
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
